// File: rtl/rgb_mixer_pkg.sv
// Shared definitions for the RGB mixer: FSM encoding, channel count and default preset colours.
package rgb_mixer_pkg;

  localparam int unsigned NUM_CH = 3;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_FADE   = 2'd1,
    ST_HOLD   = 2'd2
  } fade_state_e;

  // Default presets as per-channel full-scale masks {ch2,ch1,ch0}; each set bit means WIDTH max.
  localparam logic [NUM_CH-1:0] PRESET_RED   = 3'b001;
  localparam logic [NUM_CH-1:0] PRESET_GREEN = 3'b010;
  localparam logic [NUM_CH-1:0] PRESET_BLUE  = 3'b100;
  localparam logic [NUM_CH-1:0] PRESET_WHITE = 3'b111;

  function automatic logic [NUM_CH-1:0] default_preset_mask(input int unsigned idx);
    logic [NUM_CH-1:0] mask;
    case (idx)
      0:       mask = PRESET_RED;
      1:       mask = PRESET_GREEN;
      2:       mask = PRESET_BLUE;
      3:       mask = PRESET_WHITE;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_fade_channel.sv
// One colour channel: level register that loads a manual value or steps 1 LSB toward a target.
module fade_channel #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_en,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] level,
  output logic             at_target_c
);

  logic [WIDTH-1:0] level_d, level_q;

  assign at_target_c = (level_q == target);
  assign level       = level_q;

  // Stepping only ever closes the gap, so no overshoot or wrap is possible.
  always_comb begin
    level_d = level_q;
    if (load) begin
      level_d = load_val;
    end else if (step_en) begin
      if (level_q < target) begin
        level_d = level_q + WIDTH'(1);
      end else if (level_q > target) begin
        level_d = level_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB level controller: manual pass-through of encoder values, or automatic fade/hold
// cycling through a writable preset table.
module rgb_fade_sequencer
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NUM_PRESETS = 4,
  parameter int unsigned STEP_DIV    = 16,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            auto_en,
  input  logic [WIDTH-1:0]                enc0,
  input  logic [WIDTH-1:0]                enc1,
  input  logic [WIDTH-1:0]                enc2,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_PRESETS)-1:0]  cfg_addr,
  input  logic [NUM_CH*WIDTH-1:0]         cfg_data,
  output logic [WIDTH-1:0]                level0,
  output logic [WIDTH-1:0]                level1,
  output logic [WIDTH-1:0]                level2,
  output logic [$clog2(NUM_PRESETS)-1:0]  preset_idx,
  output logic [1:0]                      state,
  output logic                            arrived
);

  localparam int unsigned IDX_W  = $clog2(NUM_PRESETS);
  localparam int unsigned STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned COL_W  = NUM_CH * WIDTH;

  function automatic logic [COL_W-1:0] default_colour(input int unsigned idx);
    logic [NUM_CH-1:0] mask;
    logic [COL_W-1:0]  colour;
    mask = default_preset_mask(idx);
    for (int c = 0; c < NUM_CH; c++) begin
      colour[c*WIDTH +: WIDTH] = {WIDTH{mask[c]}};
    end
    return colour;
  endfunction

  fade_state_e       state_d, state_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [STEP_W-1:0] step_d, step_q;
  logic [HOLD_W-1:0] hold_d, hold_q;
  logic              arrived_d, arrived_q;
  logic [COL_W-1:0]  table_d [NUM_PRESETS];
  logic [COL_W-1:0]  table_q [NUM_PRESETS];

  logic              load_c;
  logic              step_en_c;
  logic [COL_W-1:0]  target_c;
  logic [WIDTH-1:0]  enc_arr [NUM_CH];
  logic [WIDTH-1:0]  lvl     [NUM_CH];
  logic [NUM_CH-1:0] at_c;

  assign enc_arr[0] = enc0;
  assign enc_arr[1] = enc1;
  assign enc_arr[2] = enc2;
  assign target_c   = table_q[idx_q];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fade_channel #(.WIDTH(WIDTH)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .load       (load_c),
      .load_val   (enc_arr[c]),
      .step_en    (step_en_c),
      .target     (target_c[c*WIDTH +: WIDTH]),
      .level      (lvl[c]),
      .at_target_c(at_c[c])
    );
  end

  // Preset table write port; accepted in every state.
  always_comb begin
    for (int p = 0; p < NUM_PRESETS; p++) begin
      table_d[p] = table_q[p];
    end
    if (cfg_we) begin
      table_d[cfg_addr] = cfg_data;
    end
  end

  // Sequencer: auto_en drop outranks both arrival and hold expiry.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    step_d    = step_q;
    hold_d    = hold_q;
    arrived_d = 1'b0;
    load_c    = 1'b0;
    step_en_c = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        load_c = 1'b1;
        step_d = '0;
        hold_d = '0;
        if (auto_en) begin
          state_d = ST_FADE;
        end
      end
      ST_FADE: begin
        if (!auto_en) begin
          state_d = ST_MANUAL;
          step_d  = '0;
          hold_d  = '0;
        end else if (&at_c) begin
          state_d   = ST_HOLD;
          arrived_d = 1'b1;
          hold_d    = '0;
        end else if (step_q == STEP_W'(STEP_DIV - 1)) begin
          step_en_c = 1'b1;
          step_d    = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_HOLD: begin
        if (!auto_en) begin
          state_d = ST_MANUAL;
          step_d  = '0;
          hold_d  = '0;
        end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = ST_FADE;
          idx_d   = idx_q + IDX_W'(1);
          step_d  = '0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_MANUAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_MANUAL;
      idx_q     <= '0;
      step_q    <= '0;
      hold_q    <= '0;
      arrived_q <= 1'b0;
      for (int p = 0; p < NUM_PRESETS; p++) begin
        table_q[p] <= default_colour(p);
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      step_q    <= step_d;
      hold_q    <= hold_d;
      arrived_q <= arrived_d;
      for (int p = 0; p < NUM_PRESETS; p++) begin
        table_q[p] <= table_d[p];
      end
    end
  end

  assign level0     = lvl[0];
  assign level1     = lvl[1];
  assign level2     = lvl[2];
  assign preset_idx = idx_q;
  assign state      = state_q;
  assign arrived    = arrived_q;

endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
Controller that sits between the three encoder value buses and the three PWM level inputs of the RGB mixer. In manual mode it passes the encoder values straight through. In auto mode it cycles through a small programmable preset table. It fades linearly from the current colour to each preset, then holds that colour for a fixed time before moving on.

Parameters:
WIDTH, 8, bit width of each colour channel level
NUM_PRESETS, 4, number of preset colours in the table (power of two, >=2)
STEP_DIV, 16, clock cycles per 1-LSB fade step (>=1)
HOLD_CYCLES, 1024, clock cycles spent holding a reached preset (>=1)

Ports:
clk  in  1  system clock (the divided slow clock when instanced in the mixer)
reset  in  1  synchronous, active-high reset
auto_en  in  1  1 = auto sequencing, 0 = manual pass-through
enc0  in  WIDTH  manual level, channel 0 (red)
enc1  in  WIDTH  manual level, channel 1 (green)
enc2  in  WIDTH  manual level, channel 2 (blue)
cfg_we  in  1  preset table write strobe
cfg_addr  in  log2(NUM_PRESETS)  preset index to write
cfg_data  in  3*WIDTH  preset colour {ch2,ch1,ch0}
level0  out  WIDTH  PWM level, channel 0
level1  out  WIDTH  PWM level, channel 1
level2  out  WIDTH  PWM level, channel 2
preset_idx  out  log2(NUM_PRESETS)  current target preset
state  out  2  FSM state encoding
arrived  out  1  one-cycle pulse when all channels reach the target

Behaviour:
- Reset (sync, active-high, overrides everything):
  - levels = 0, state = MANUAL, preset_idx = 0, arrived = 0, step and hold counters = 0.
  - Preset defaults: 0 = {0,0,max} (red), 1 = {0,max,0}, 2 = {max,0,0}, 3 = {max,max,max}; entries above 3 = 0.
- Preset table is registered.
  - cfg_we writes on the clock edge and is accepted in every state.
  - The target colour is read combinationally from table[preset_idx], so a write to the active entry redirects an in-progress fade on the next cycle.
- States: MANUAL(0), FADE(1), HOLD(2).
- MANUAL:
  - levelN <= encN every cycle (1-cycle latency).
  - auto_en=1 -> FADE next cycle; preset_idx unchanged; step counter cleared.
- FADE:
  - The step counter counts 0..STEP_DIV-1.
  - On the cycle the counter equals STEP_DIV-1, each channel moves 1 LSB toward its target; a channel already equal to its target stays put. No overshoot, no wrap.
  - On the cycle all three levels equal the target (evaluated on registered levels, including on entry): arrived=1 for one cycle, hold counter cleared, -> HOLD.
- HOLD:
  - Levels frozen; the hold counter increments each cycle.
  - At HOLD_CYCLES-1: preset_idx <= (preset_idx+1) mod NUM_PRESETS (wraps), step counter cleared, -> FADE.
  - If the active entry is rewritten during HOLD, the hold continues; the new value is faded to on the next visit.
- auto_en=0 in FADE or HOLD -> MANUAL next cycle, from which levels track enc.
  - Counters are cleared; preset_idx is retained.
  - No arrived pulse is generated.
- Simultaneous events:
  - auto_en drop has priority over arrival and over hold expiry.
  - Reset has priority over all.
- arrived is 0 in all cycles except the single arrival cycle.
- Up to STEP_DIV cycles elapse from entering FADE to the first step.

Decomposition:
- Shared package rgb_mixer_pkg holds:
  - state encoding constants MANUAL/FADE/HOLD;
  - channel-count constant 3;
  - default preset colour constants, expressed relative to WIDTH max.
- One natural sub-module: fade_channel.
  - Per-channel level register with load (manual value), step enable, and target compare.
  - Outputs level and at_target.
  - Instantiated three times; the FSM, counters and preset table stay in the top.

Test Plan:
Use WIDTH=8, STEP_DIV=2, HOLD_CYCLES=4 unless noted.
1. Reset then manual: reset 1 cycle, auto_en=0, enc0/1/2=0x12/0x34/0x56 -> levels 0 during reset, then 0x12/0x34/0x56 one cycle after reset release; state=0.
2. Fade to default preset 0: levels 0x00, auto_en=1 -> level0 increments by 1 every 2 cycles, level1/2 stay 0; after 255 steps level0=0xFF, arrived pulses once, state=2.
3. Hold and wrap: WIDTH=2, NUM_PRESETS=4, run auto mode -> each preset held exactly 4 cycles, preset_idx sequence 0,1,2,3,0; 4 arrived pulses per full cycle.
4. Mid-fade redirect: fading toward 0xFF with level0=0x40, write cfg_addr=0, cfg_data={0,0,0x20} -> level0 decrements from 0x40 to 0x20, then arrives with no overshoot.
5. Abort: auto_en dropped in FADE on the same cycle levels would reach the target -> state=MANUAL next cycle, no arrived pulse, levels=enc one cycle later, preset_idx retained.
6. Reset mid-HOLD: assert reset in HOLD with preset_idx=2 -> the next cycle shows levels 0, preset_idx 0, state 0, and the preset table restored to defaults.
